// File: rtl/snoop_responder.sv
// MSI snoop responder: a small direct-mapped tag/state table that answers bus
// snoops, issuing a write-back for read/write misses that hit a Modified line.
module snoop_responder #(
  parameter int IDX_W = 2,
  parameter int TAG_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   bus_valid,
  input  logic [1:0]             bus_cmd,
  input  logic [IDX_W+TAG_W-1:0] bus_addr,
  output logic                   bus_ready,
  input  logic                   fill_valid,
  input  logic [IDX_W+TAG_W-1:0] fill_addr,
  input  logic [1:0]             fill_state,
  output logic                   wb_req,
  output logic [IDX_W+TAG_W-1:0] wb_addr,
  input  logic                   wb_done,
  output logic                   snoop_ack,
  output logic                   snoop_hit,
  output logic [1:0]             new_state
);

  localparam int AW    = IDX_W + TAG_W;
  localparam int LINES = 2 ** IDX_W;

  localparam logic [1:0] ST_I   = 2'b00;
  localparam logic [1:0] ST_S   = 2'b01;
  localparam logic [1:0] ST_M   = 2'b10;
  localparam logic [1:0] CMD_RD  = 2'b01;
  localparam logic [1:0] CMD_INV = 2'b11;

  typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, ACK} fsm_t;

  fsm_t cur, nxt;

  logic [TAG_W-1:0] tags   [LINES];
  logic [1:0]       states [LINES];

  logic [1:0]    cmd_q;
  logic [AW-1:0] addr_q;
  logic          hit_q;
  logic [1:0]    ns_q;

  logic [IDX_W-1:0] idx_q;
  logic [TAG_W-1:0] tag_q;
  logic [TAG_W-1:0] line_tag;
  logic [1:0]       line_st;
  logic             lk_hit;
  logic             lk_wb;
  logic [1:0]       lk_ns;
  logic             accept;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic [1:0]       fill_st;

  assign idx_q    = addr_q[IDX_W-1:0];
  assign tag_q    = addr_q[AW-1:IDX_W];
  assign line_tag = tags[idx_q];
  assign line_st  = states[idx_q];
  assign lk_hit   = (line_st != ST_I) && (line_tag == tag_q);
  assign accept   = bus_valid && (bus_cmd != 2'b00);
  assign fill_idx = fill_addr[IDX_W-1:0];
  assign fill_tag = fill_addr[AW-1:IDX_W];
  assign fill_st  = (fill_state == 2'b11) ? ST_I : fill_state;

  // Line still holds M throughout WRITEBACK (fills are dropped), so lk_ns
  // stays valid for the deferred state update on wb_done.
  always_comb begin
    lk_ns = line_st;
    lk_wb = 1'b0;
    if (lk_hit) begin
      case (line_st)
        ST_M: begin
          lk_ns = (cmd_q == CMD_RD) ? ST_S : ST_I;
          lk_wb = (cmd_q != CMD_INV);
        end
        ST_S:    lk_ns = (cmd_q == CMD_RD) ? ST_S : ST_I;
        default: lk_ns = line_st;
      endcase
    end
  end

  always_comb begin
    nxt       = cur;
    bus_ready = 1'b0;
    wb_req    = 1'b0;
    wb_addr   = '0;
    snoop_ack = 1'b0;
    snoop_hit = 1'b0;
    new_state = '0;
    case (cur)
      IDLE: begin
        bus_ready = 1'b1;
        if (accept) nxt = LOOKUP;
      end
      LOOKUP: nxt = lk_wb ? WRITEBACK : ACK;
      WRITEBACK: begin
        wb_req  = 1'b1;
        wb_addr = {line_tag, idx_q};
        if (wb_done) nxt = ACK;
      end
      ACK: begin
        snoop_ack = 1'b1;
        snoop_hit = hit_q;
        new_state = ns_q;
        nxt       = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur    <= IDLE;
      tags   <= '{default: '0};
      states <= '{default: ST_I};
      cmd_q  <= '0;
      addr_q <= '0;
      hit_q  <= 1'b0;
      ns_q   <= '0;
    end else begin
      cur <= nxt;
      case (cur)
        IDLE: begin
          if (accept) begin
            cmd_q  <= bus_cmd;
            addr_q <= bus_addr;
          end else if (fill_valid) begin
            tags[fill_idx]   <= fill_tag;
            states[fill_idx] <= fill_st;
          end
        end
        LOOKUP: begin
          hit_q <= lk_hit;
          ns_q  <= lk_ns;
          if (!lk_wb) states[idx_q] <= lk_ns;
        end
        WRITEBACK: begin
          if (wb_done) states[idx_q] <= lk_ns;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snoop_responder.sv
// Directed bench for snoop_responder: per-cycle comparison against a table-level
// MSI model, plus literal pins on the key cycles of each directed vector.
module tb_snoop_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bus_valid = 1'b0;
  logic [1:0] bus_cmd = 2'b00;
  logic [3:0] bus_addr = 4'h0;
  logic       bus_ready;
  logic       fill_valid = 1'b0;
  logic [3:0] fill_addr = 4'h0;
  logic [1:0] fill_state = 2'b00;
  logic       wb_req;
  logic [3:0] wb_addr;
  logic       wb_done = 1'b0;
  logic       snoop_ack;
  logic       snoop_hit;
  logic [1:0] new_state;

  snoop_responder #(.IDX_W(2), .TAG_W(2)) dut (
    .clk(clk), .rst(rst),
    .bus_valid(bus_valid), .bus_cmd(bus_cmd), .bus_addr(bus_addr), .bus_ready(bus_ready),
    .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_state(fill_state),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_done(wb_done),
    .snoop_ack(snoop_ack), .snoop_hit(snoop_hit), .new_state(new_state)
  );

  always #5 clk = ~clk;

  // Model of the line table
  logic [1:0] mtag [4];
  logic [1:0] mst  [4];

  // Model expectations for the current cycle
  logic       chk_en = 1'b0;
  logic       e_ready, e_wbreq, e_ack, e_hit;
  logic [3:0] e_wbaddr;
  logic [1:0] e_ns;
  // Hand-computed literal pins for selected cycles
  logic       pin_en = 1'b0;
  logic       p_ready, p_wbreq, p_ack, p_hit;
  logic [3:0] p_wbaddr;
  logic [1:0] p_ns;

  int n_cmp = 0;
  int n_err = 0;

  task automatic cmp(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("bus_ready", 4'(bus_ready), 4'(e_ready));
      cmp("wb_req", 4'(wb_req), 4'(e_wbreq));
      if (e_wbreq) cmp("wb_addr", wb_addr, e_wbaddr);
      cmp("snoop_ack", 4'(snoop_ack), 4'(e_ack));
      cmp("snoop_hit", 4'(snoop_hit), 4'(e_hit));
      cmp("new_state", 4'(new_state), 4'(e_ns));
      if (pin_en) begin
        cmp("pin_bus_ready", 4'(bus_ready), 4'(p_ready));
        cmp("pin_wb_req", 4'(wb_req), 4'(p_wbreq));
        if (p_wbreq) cmp("pin_wb_addr", wb_addr, p_wbaddr);
        cmp("pin_snoop_ack", 4'(snoop_ack), 4'(p_ack));
        cmp("pin_snoop_hit", 4'(snoop_hit), 4'(p_hit));
        cmp("pin_new_state", 4'(new_state), 4'(p_ns));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic rdy);
    e_ready = rdy; e_wbreq = 1'b0; e_wbaddr = 4'h0;
    e_ack = 1'b0; e_hit = 1'b0; e_ns = 2'b00;
    pin_en = 1'b0;
  endtask

  task automatic pin_idle;
    pin_en = 1'b1; p_ready = 1'b1; p_wbreq = 1'b0; p_wbaddr = 4'h0;
    p_ack = 1'b0; p_hit = 1'b0; p_ns = 2'b00;
  endtask

  task automatic model_clear;
    for (int i = 0; i < 4; i++) begin
      mtag[i] = 2'b00;
      mst[i]  = 2'b00;
    end
  endtask

  task automatic fill(input logic [3:0] a, input logic [1:0] s);
    fill_valid = 1'b1; fill_addr = a; fill_state = s;
    set_exp(1'b1);
    tick;
    fill_valid = 1'b0;
    mtag[a[1:0]] = a[3:2];
    mst[a[1:0]]  = (s == 2'b11) ? 2'b00 : s;
    set_exp(1'b1);
  endtask

  // One snoop; fs = fill in the acceptance cycle, fl = fill during LOOKUP.
  // lh/lns are the hand-computed hit/new_state; wbd = wb_done delay in cycles.
  task automatic snoop(input logic [1:0] cmd, input logic [3:0] a, input int wbd,
                       input bit fs, input bit fl, input logic lh, input logic [1:0] lns);
    logic [1:0] idx, st, ns;
    logic       hit, wb;
    idx = a[1:0];
    bus_valid = 1'b1; bus_cmd = cmd; bus_addr = a;
    if (fs) begin fill_valid = 1'b1; fill_addr = a; fill_state = 2'b10; end
    set_exp(1'b1);
    tick;
    bus_valid = 1'b0; fill_valid = 1'b0;
    if (fl) begin fill_valid = 1'b1; fill_addr = a; fill_state = 2'b10; end
    set_exp(1'b0);
    st  = mst[idx];
    hit = (st != 2'b00) && (mtag[idx] == a[3:2]);
    if (!hit) begin
      ns = st; wb = 1'b0;
    end else if (cmd == 2'b01) begin
      ns = 2'b01; wb = (st == 2'b10);
    end else begin
      ns = 2'b00; wb = (st == 2'b10) && (cmd == 2'b10);
    end
    tick;
    fill_valid = 1'b0;
    if (wb) begin
      for (int k = 0; k <= wbd; k++) begin
        set_exp(1'b0);
        e_wbreq = 1'b1; e_wbaddr = {mtag[idx], idx};
        pin_idle; p_ready = 1'b0; p_wbreq = 1'b1; p_wbaddr = a;
        wb_done = (k == wbd);
        tick;
      end
      wb_done = 1'b0;
    end
    set_exp(1'b0);
    e_ack = 1'b1; e_hit = hit; e_ns = ns;
    pin_idle; p_ready = 1'b0; p_ack = 1'b1; p_hit = lh; p_ns = lns;
    mst[idx] = ns;
    tick;
    set_exp(1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    model_clear();
    set_exp(1'b1);
    tick;
    tick;
    rst = 1'b0;
    chk_en = 1'b1;
    set_exp(1'b1); pin_idle;
    tick;
    set_exp(1'b1);

    // Modified line, read miss: write-back after 3 wait cycles, M->S
    fill(4'b0110, 2'b10);
    snoop(2'b01, 4'b0110, 3, 0, 0, 1'b1, 2'b01);
    // Shared line, write miss: S->I, no write-back
    fill(4'b0011, 2'b01);
    snoop(2'b10, 4'b0011, 0, 0, 0, 1'b1, 2'b00);
    // Tag mismatch on an M line: miss reports stored state, line unchanged
    fill(4'b1001, 2'b10);
    snoop(2'b01, 4'b0101, 0, 0, 0, 1'b0, 2'b10);
    snoop(2'b10, 4'b1001, 0, 0, 0, 1'b1, 2'b00);
    // Invalidate hitting M: no write-back
    fill(4'b1110, 2'b10);
    snoop(2'b11, 4'b1110, 0, 0, 0, 1'b1, 2'b00);
    // Simultaneous bus+fill: fill dropped
    snoop(2'b01, 4'b0000, 0, 1, 0, 1'b0, 2'b00);
    snoop(2'b01, 4'b0000, 0, 0, 0, 1'b0, 2'b00);
    // Fill during LOOKUP dropped
    snoop(2'b01, 4'b0100, 0, 0, 1, 1'b0, 2'b00);
    snoop(2'b01, 4'b0100, 0, 0, 0, 1'b0, 2'b00);
    // bus_cmd=00 is ignored so the concurrent fill lands
    bus_valid = 1'b1; bus_cmd = 2'b00; bus_addr = 4'b0001;
    fill_valid = 1'b1; fill_addr = 4'b0001; fill_state = 2'b01;
    set_exp(1'b1);
    tick;
    bus_valid = 1'b0; fill_valid = 1'b0;
    mtag[1] = 2'b00; mst[1] = 2'b01;
    set_exp(1'b1); pin_idle;
    tick;
    snoop(2'b01, 4'b0001, 0, 0, 0, 1'b1, 2'b01);
    // fill_state 11 installs I
    fill(4'b0111, 2'b11);
    snoop(2'b01, 4'b0111, 0, 0, 0, 1'b0, 2'b00);
    fill(4'b0111, 2'b01);
    snoop(2'b01, 4'b0111, 0, 0, 0, 1'b1, 2'b01);
    snoop(2'b11, 4'b0111, 0, 0, 0, 1'b1, 2'b00);
    // Invalidate miss; then M write miss with 1-cycle write-back wait
    fill(4'b1011, 2'b10);
    snoop(2'b11, 4'b0111, 0, 0, 0, 1'b0, 2'b10);
    snoop(2'b10, 4'b1011, 1, 0, 0, 1'b1, 2'b00);
    // Stray wb_done in IDLE
    wb_done = 1'b1;
    set_exp(1'b1);
    tick;
    wb_done = 1'b0;
    set_exp(1'b1);
    tick;

    // Reset during WRITEBACK aborts the snoop and clears all lines
    fill(4'b0110, 2'b10);
    fill(4'b1011, 2'b01);
    bus_valid = 1'b1; bus_cmd = 2'b01; bus_addr = 4'b0110;
    set_exp(1'b1);
    tick;
    bus_valid = 1'b0;
    set_exp(1'b0);
    tick;
    set_exp(1'b0); e_wbreq = 1'b1; e_wbaddr = {mtag[2], 2'b10};
    tick;
    set_exp(1'b0); e_wbreq = 1'b1; e_wbaddr = {mtag[2], 2'b10};
    rst = 1'b1;
    tick;
    rst = 1'b0;
    model_clear();
    set_exp(1'b1); pin_idle;
    tick;
    set_exp(1'b1); pin_idle;
    tick;
    set_exp(1'b1);
    snoop(2'b01, 4'b0110, 0, 0, 0, 1'b0, 2'b00);
    snoop(2'b01, 4'b1011, 0, 0, 0, 1'b0, 2'b00);
    tick;

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/snoop_responder.md
SNOOP_RESPONDER -- requirements
Module: snoop_responder

Interface
REQ-001 SHALL have parameter IDX_W, default 2, index width; the table holds 2**IDX_W lines.
REQ-002 SHALL have parameter TAG_W, default 2, tag width; the bus address width is IDX_W+TAG_W.
REQ-003 Clock  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 bus_valid  input  1  a snooped bus transaction is present.
REQ-006 bus_cmd  input  2  00 none, 01 read miss, 10 write miss, 11 invalidate.
REQ-007 bus_addr  input  IDX_W+TAG_W  address; index = low IDX_W bits, tag = high TAG_W bits.
REQ-008 bus_ready  output  1  high when the block can accept a bus transaction.
REQ-009 fill_valid  input  1  local processor installs or updates a line.
REQ-010 fill_addr  input  IDX_W+TAG_W  line address for the fill.
REQ-011 fill_state  input  2  MSI state to install: 00 I, 01 S, 10 M; 11 is treated as I.
REQ-012 wb_req  output  1  write-back request, held until wb_done.
REQ-013 wb_addr  output  IDX_W+TAG_W  address of the line being written back.
REQ-014 wb_done  input  1  memory accepted the write-back.
REQ-015 snoop_ack  output  1  one-cycle pulse that completes a snoop.
REQ-016 snoop_hit  output  1  valid with snoop_ack; tag matched and the line was not I.
REQ-017 new_state  output  2  valid with snoop_ack; the line state after the snoop.

Function
REQ-018 SHALL hold per line a TAG_W tag and a 2-bit MSI state.
REQ-019 SHALL implement the FSM states IDLE, LOOKUP, WRITEBACK, ACK.
REQ-020 bus_ready SHALL be 1 only in IDLE.
REQ-021 In IDLE, bus_valid=1 with bus_cmd!=00 SHALL latch cmd and addr and go to LOOKUP.
REQ-022 In IDLE, bus_valid=1 with bus_cmd=00 SHALL be ignored.
REQ-023 In IDLE, fill_valid=1 with no accepted bus transaction SHALL write tag and state into the indexed line in that cycle; the FSM stays in IDLE.
REQ-024 A simultaneous bus transaction and fill SHALL give the bus priority; the fill is dropped; fills outside IDLE are dropped.
REQ-025 LOOKUP: hit = (stored tag == latched tag) and state != I.
REQ-026 LOOKUP, hit in M with cmd read miss or write miss SHALL go to WRITEBACK.
REQ-027 LOOKUP, all other cases SHALL update the state and go to ACK.
REQ-028 Transitions on hit in M, read miss: M->S.
REQ-029 Transitions on hit in M, write miss or invalidate: M->I.
REQ-030 Transitions on hit in S: read miss S->S; write miss or invalidate S->I.
REQ-031 Transitions on a miss: no change, and new_state reports the stored state of the line.
REQ-032 An invalidate hitting M SHALL NOT write back.
REQ-033 WRITEBACK SHALL drive wb_req=1 and wb_addr = stored tag concatenated with index.
REQ-034 WRITEBACK SHALL remain until wb_done=1; on that edge it updates the state per REQ-028..029 and goes to ACK.
REQ-035 wb_done outside WRITEBACK SHALL be ignored.
REQ-036 ACK SHALL pulse snoop_ack for exactly one cycle, drive snoop_hit and new_state, and return to IDLE.
REQ-037 Latency from acceptance to snoop_ack: 2 cycles without a write-back; 2 cycles plus wb_done wait with a write-back.
REQ-038 snoop_hit and new_state SHALL be 0 outside ACK.

Reset
REQ-039 Reset=1 SHALL, at the next edge, force IDLE, all line states I, all tags 0, and wb_req, snoop_ack, snoop_hit, new_state = 0.
REQ-040 Reset SHALL abort any in-flight snoop, including WRITEBACK, with no ack issued.
REQ-041 bus_ready SHALL be 1 in the cycle after reset deasserts.

Verification
REQ-042 Fill addr 4'b0110 state M; bus read miss addr 0110 -> wb_req=1, wb_addr=0110 in WRITEBACK; wb_done after 3 cycles -> snoop_ack, snoop_hit=1, new_state=01.
REQ-043 Fill addr 0011 state S; bus write miss 0011 -> snoop_ack 2 cycles after acceptance, hit=1, new_state=00, wb_req never asserted.
REQ-044 Line 01 holds tag 10 in M; bus read miss 0101 (tag 01) -> hit=0, new_state=10, line unchanged.
REQ-045 Line in M; bus invalidate to the same address -> no write-back, hit=1, new_state=00.
REQ-046 bus_valid and fill_valid in the same IDLE cycle -> the snoop is processed and the fill is not written.
REQ-047 Reset asserted during WRITEBACK -> wb_req=0 next cycle, no snoop_ack, all lines I.
